uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Sequences the UART receiver byte stream for the CPU core.
- After reset it runs a boot-load phase: a 32-bit length word, then that many 32-bit instruction words, written into instruction memory.
- It then switches to run mode, where received bytes are buffered in a show-ahead FIFO that the CPU's input instruction pops.

Parameters:
- ADDR_WIDTH, 14, instruction-memory word address width.
- FIFO_LOG2, 4, log2 of FIFO depth (default 16 entries).

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from receiver; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle pulse per received byte.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address for imem_we.
- imem_wdata  out  32  instruction word for imem_we.
- boot_done  out  1  high once run mode is entered; stays high until RST.
- cpu_rd_en  in  1  pop the FIFO head this cycle.
- cpu_rd_data  out  8  FIFO head byte (show-ahead); undefined when rx_empty=1.
- rx_empty  out  1  FIFO holds no bytes.
- rx_overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- ovf_clr  in  1  clears rx_overflow.

Behaviour:
- Reset (RST=1, asynchronous), all outputs and state take these values:
  - state = LEN, byte counter = 0, word counter = 0.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - boot_done = 0, rx_empty = 1, rx_overflow = 0.
  - FIFO pointers = 0, length register = 0.
- Byte assembly (LEN and DATA states): big-endian. The first byte of each group goes to bits [31:24]. A 2-bit byte counter advances on each rx_valid and wraps 3->0.
- State LEN:
  - Collect 4 bytes into the 32-bit length register N.
  - On the 4th byte: if N=0, go to RUN directly; else go to DATA with word counter = 0.
- State DATA:
  - On each 4th byte, the next cycle drives imem_we=1 for exactly one cycle, with imem_addr = word counter[ADDR_WIDTH-1:0] and imem_wdata = assembled word. Latency is 1 cycle after the 4th rx_valid.
  - imem_addr/imem_wdata hold their last values when imem_we=0.
  - The word counter is 32 bits and increments after each write. Addresses wrap modulo 2^ADDR_WIDTH when N exceeds memory size; no error is flagged.
  - When the counter reaches N, go to RUN in the same cycle the last imem_we is driven.
- State RUN:
  - boot_done=1 from the first RUN cycle.
  - rx_valid pushes rx_data into the FIFO. No byte received during LEN/DATA ever enters the FIFO.
  - cpu_rd_en with rx_empty=0 pops the head. cpu_rd_data shows the new head (or is undefined) the next cycle.
  - cpu_rd_en with rx_empty=1 is ignored; pointers are unchanged.
  - Simultaneous push and pop when full: both happen, occupancy stays full, no overflow.
  - Simultaneous push and pop when empty: push only.
  - Push when full without a pop: byte dropped and rx_overflow=1 next cycle.
  - ovf_clr=1 clears rx_overflow next cycle. If an overflow occurs in the same cycle, the set wins.
  - Occupancy tracking uses FIFO_LOG2+1-bit pointers. rx_empty and full are registered-pointer compares, so rx_empty falls the cycle after the first push.
- cpu_rd_en and ovf_clr are ignored outside RUN.
- RST asserted mid-load aborts the load immediately:
  - no further imem_we;
  - partial bytes are discarded;
  - the load restarts from LEN after release.
- rx_valid is never asserted on consecutive cycles by the receiver. The block need not handle back-to-back pulses in LEN/DATA, but the FIFO path must.

Test Plan:
- Reset mid-DATA: send length 2 and 5 bytes, pulse RST, then send length 0 -> no imem_we after RST, boot_done=1, rx_empty=1.
- Boot load: send 00 00 00 02, 12 34 56 78, 9A BC DE F0 -> two imem_we pulses, each one cycle after its 4th byte: (addr 0, 0x12345678) then (addr 1, 0x9ABCDEF0). boot_done rises with the second write and a following byte 0x41 appears on cpu_rd_data.
- Zero-length boot: send 00 00 00 00 -> no imem_we, boot_done=1 the cycle after the 4th byte, next byte 0x55 enters the FIFO.
- FIFO order/empty: in RUN push 0x01,0x02,0x03 and pop three times -> data read 01,02,03, rx_empty=1 after the third pop, and a fourth cpu_rd_en changes nothing.
- Overflow:
  - push 17 bytes into the 16-deep FIFO with no pops -> rx_overflow=1 and the 17th byte is lost; draining yields bytes 1..16.
  - ovf_clr then clears rx_overflow.
  - With a full FIFO, push and pop in the same cycle -> rx_overflow stays 0 and the occupancy count is unchanged.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: boot-loads instruction memory from the UART byte stream, then buffers run-mode bytes in a FIFO.
module uart_rx_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int FIFO_LOG2  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  boot_done,
    input  logic                  cpu_rd_en,
    output logic [7:0]            cpu_rd_data,
    output logic                  rx_empty,
    output logic                  rx_overflow,
    input  logic                  ovf_clr
);
    localparam int DEPTH = 1 << FIFO_LOG2;

    typedef enum logic [1:0] {LEN, DATA, RUN} state_t;

    state_t               state, state_nx;
    logic [1:0]           byte_cnt;
    logic [23:0]          shift;
    logic [31:0]          len, word_cnt, word;
    logic [FIFO_LOG2:0]   wr_ptr, rd_ptr;
    logic [7:0]           mem [DEPTH];
    logic                 run, last_byte, full, push, pop, ovf_set;

    assign run       = state == RUN;
    assign last_byte = rx_valid && byte_cnt == 2'd3;
    assign word      = {shift, rx_data};
    assign boot_done = run;

    // Extra pointer bit separates full from empty when the indices match.
    assign rx_empty    = wr_ptr == rd_ptr;
    assign full        = (wr_ptr ^ rd_ptr) == {1'b1, {FIFO_LOG2{1'b0}}};
    assign pop         = run && cpu_rd_en && !rx_empty;
    assign push        = run && rx_valid && (!full || pop);
    assign ovf_set     = run && rx_valid && full && !pop;
    assign cpu_rd_data = mem[rd_ptr[FIFO_LOG2-1:0]];

    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= LEN;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (last_byte && state == LEN)
            state_nx = (word == 32'd0) ? RUN : DATA;
        else if (last_byte && state == DATA && word_cnt + 32'd1 == len)
            state_nx = RUN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            byte_cnt   <= 2'd0;
            shift      <= 24'd0;
            len        <= 32'd0;
            word_cnt   <= 32'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (!run && rx_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= word[23:0];
            end
            if (state == LEN && last_byte) begin
                len      <= word;
                word_cnt <= 32'd0;
            end
            if (state == DATA && last_byte) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                imem_wdata <= word;
                word_cnt   <= word_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            rx_overflow <= ovf_set ? 1'b1 : (run && ovf_clr) ? 1'b0 : rx_overflow;
        end
    end

    always_ff @(posedge CLK)
        if (push) mem[wr_ptr[FIFO_LOG2-1:0]] <= rx_data;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized and directed checks of boot load and run-mode FIFO against a queue model.
module tb_uart_rx_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        imem_we;
    logic [13:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        boot_done;
    logic        cpu_rd_en = 1'b0;
    logic [7:0]  cpu_rd_data;
    logic        rx_empty;
    logic        rx_overflow;
    logic        ovf_clr = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          we_count = 0;
    logic [31:0] bw[$];
    logic [7:0]  mq[$];
    bit          movf = 1'b0;

    uart_rx_ctrl dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .boot_done(boot_done), .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data),
        .rx_empty(rx_empty), .rx_overflow(rx_overflow), .ovf_clr(ovf_clr)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK)
        if (imem_we) we_count <= we_count + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(1, 3)) begin
            cpu_rd_en = 1'($urandom);
            ovf_clr   = 1'($urandom);
            tick();
        end
        cpu_rd_en = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Big-endian; returns right after the edge that consumed the last byte.
    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8]);
            if (i != 0) gap();
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        rx_valid = 1'b0;
        cpu_rd_en = 1'b0;
        ovf_clr = 1'b0;
        #2;
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_boot_done", boot_done, 0);
        check("rst_empty", rx_empty, 1);
        check("rst_ovf", rx_overflow, 0);
        #2;
        RST = 1'b0;
        mq.delete();
        movf = 1'b0;
        tick();
    endtask

    task automatic do_boot();
        int n;
        int we0;
        n   = bw.size();
        we0 = we_count;
        send_word(32'(n));
        check("len_we", imem_we, 0);
        check("len_boot_done", boot_done, 32'(n == 0));
        gap();
        for (int k = 0; k < n; k++) begin
            send_word(bw[k]);
            check("boot_we", imem_we, 1);
            check("boot_addr", imem_addr, 32'(k % 16384));
            check("boot_wdata", imem_wdata, bw[k]);
            check("boot_done_edge", boot_done, 32'(k == n - 1));
            gap();
        end
        check("boot_we_count", we_count - we0, n);
        check("boot_empty", rx_empty, 1);
        check("boot_done", boot_done, 1);
    endtask

    // One run-mode cycle; the model applies the pop before the push.
    task automatic run_cycle(input bit push, input logic [7:0] d, input bit pop, input bit clr);
        bit pop_ok, dropped;
        pop_ok  = pop && mq.size() > 0;
        dropped = push && mq.size() == 16 && !pop_ok;
        rx_valid  = push;
        rx_data   = d;
        cpu_rd_en = pop;
        ovf_clr   = clr;
        tick();
        rx_valid  = 1'b0;
        cpu_rd_en = 1'b0;
        ovf_clr   = 1'b0;
        if (pop_ok) void'(mq.pop_front());
        if (push && !dropped) mq.push_back(d);
        if (dropped) movf = 1'b1;
        else if (clr) movf = 1'b0;
        check("run_empty", rx_empty, 32'(mq.size() == 0));
        check("run_ovf", rx_overflow, 32'(movf));
        if (mq.size() > 0) check("run_head", cpu_rd_data, mq[0]);
    endtask

    initial begin
        #1;
        do_reset();

        // Abort mid-load, then a zero-length boot.
        send_word(32'd2);
        gap();
        send_word(32'h12345678);
        check("abort_first_we", imem_we, 1);
        gap();
        send_byte(8'h9A);
        gap();
        do_reset();
        bw.delete();
        do_boot();

        // Two-word boot followed by a run-mode byte.
        do_reset();
        bw = '{32'h12345678, 32'h9ABCDEF0};
        do_boot();
        run_cycle(1, 8'h41, 0, 0);
        check("rd_41", cpu_rd_data, 8'h41);

        // Zero-length boot, then FIFO order and empty-pop.
        do_reset();
        bw.delete();
        do_boot();
        run_cycle(1, 8'h55, 0, 0);
        check("rd_55", cpu_rd_data, 8'h55);
        run_cycle(0, 8'h00, 1, 0);
        run_cycle(1, 8'h01, 0, 0);
        run_cycle(1, 8'h02, 0, 0);
        run_cycle(1, 8'h03, 0, 0);
        for (int i = 0; i < 4; i++) run_cycle(0, 8'h00, 1, 0);
        check("order_empty", rx_empty, 1);

        // Overflow: 17 pushes, drain, clear, then full push+pop.
        for (int i = 1; i <= 17; i++) run_cycle(1, 8'(i), 0, 0);
        check("ovf_set", rx_overflow, 1);
        for (int i = 1; i <= 16; i++) begin
            check("drain_data", cpu_rd_data, 8'(i));
            run_cycle(0, 8'h00, 1, 0);
        end
        run_cycle(0, 8'h00, 0, 1);
        check("ovf_cleared", rx_overflow, 0);
        for (int i = 0; i < 16; i++) run_cycle(1, 8'(8'hA0 + i), 0, 0);
        run_cycle(1, 8'hEE, 1, 0);
        check("full_pushpop_ovf", rx_overflow, 0);
        for (int i = 0; i < 16; i++) run_cycle(0, 8'h00, 1, 0);
        check("full_pushpop_empty", rx_empty, 1);
        run_cycle(1, 8'h77, 0, 1);
        run_cycle(1, 8'h78, 0, 0);

        // Randomized boots and run-mode traffic.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            bw.delete();
            repeat ($urandom_range(0, 4)) bw.push_back($urandom);
            do_boot();
            for (int i = 0; i < 1200; i++) begin
                bit hi;
                hi = ((i / 200) % 2) == 1;
                run_cycle($urandom_range(0, 99) < (hi ? 85 : 30), 8'($urandom),
                          $urandom_range(0, 99) < (hi ? 25 : 70), $urandom_range(0, 39) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
